// File: rtl/perf_counter_reporter_if.sv
// Valid/ready byte stream from the counter reporter to the debug UART transmitter.
interface perf_counter_reporter_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;

    // Byte source: presents bytes, observes sink readiness
    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    // Byte sink: consumes bytes, signals readiness
    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/perf_counter_reporter.sv
// Snapshots four performance counters on program completion or a manual
// request, then streams them as a 14-byte frame (header, 4x24-bit counters
// MSB first, XOR checksum) over a valid/ready byte interface.
module perf_counter_reporter #(
    parameter logic [7:0] HEADER = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     finish,
    input  logic                     report_req,
    input  logic [18:0]              instruction_count,
    input  logic [18:0]              aritmetric_count,
    input  logic [18:0]              memory_count,
    input  logic [18:0]              stall_count,
    perf_counter_reporter_if.master  tx,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned CNT_W    = 19;
    localparam int unsigned WIRE_W   = 24;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned LAST_IDX = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
    logic [BYTE_W-1:0]   csum_q, csum_d;
    logic [CNT_W-1:0]    snap_instr_q, snap_instr_d;
    logic [CNT_W-1:0]    snap_arith_q, snap_arith_d;
    logic [CNT_W-1:0]    snap_mem_q, snap_mem_d;
    logic [CNT_W-1:0]    snap_stall_q, snap_stall_d;
    logic                tx_valid_q, tx_valid_d;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                finish_q;

    logic                trigger_c;
    logic [BYTE_W-1:0]   csum_acc_c;

    // Selects the frame byte for a given position from the snapshot set
    function automatic logic [BYTE_W-1:0] frame_byte(
        input logic [IDX_W-1:0]  idx,
        input logic [BYTE_W-1:0] csum,
        input logic [CNT_W-1:0]  c_instr,
        input logic [CNT_W-1:0]  c_arith,
        input logic [CNT_W-1:0]  c_mem,
        input logic [CNT_W-1:0]  c_stall
    );
        logic [WIRE_W-1:0] word;
        logic [BYTE_W-1:0] b;
        word = '0;
        b    = '0;
        case (idx)
            4'd1, 4'd2, 4'd3:    word = WIRE_W'(c_instr);
            4'd4, 4'd5, 4'd6:    word = WIRE_W'(c_arith);
            4'd7, 4'd8, 4'd9:    word = WIRE_W'(c_mem);
            4'd10, 4'd11, 4'd12: word = WIRE_W'(c_stall);
            default:             word = '0;
        endcase
        case (idx)
            4'd0:                         b = HEADER;
            4'd1, 4'd4, 4'd7, 4'd10:      b = word[23:16];
            4'd2, 4'd5, 4'd8, 4'd11:      b = word[15:8];
            4'd3, 4'd6, 4'd9, 4'd12:      b = word[7:0];
            default:                      b = csum;
        endcase
        return b;
    endfunction

    // Rising edge of finish or a manual request starts a frame (only used in IDLE)
    assign trigger_c  = (finish & ~finish_q) | report_req;
    // Checksum including the byte currently on the bus
    assign csum_acc_c = csum_q ^ tx_data_q;

    assign tx.tx_valid = tx_valid_q;
    assign tx.tx_data  = tx_data_q;
    assign busy        = busy_q;
    assign done        = done_q;

    // Finish edge detector; resets high so a level already asserted never triggers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            finish_q <= 1'b1;
        end else begin
            finish_q <= finish;
        end
    end

    // State, snapshot and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            byte_idx_q   <= '0;
            csum_q       <= '0;
            snap_instr_q <= '0;
            snap_arith_q <= '0;
            snap_mem_q   <= '0;
            snap_stall_q <= '0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            csum_q       <= csum_d;
            snap_instr_q <= snap_instr_d;
            snap_arith_q <= snap_arith_d;
            snap_mem_q   <= snap_mem_d;
            snap_stall_q <= snap_stall_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        csum_d       = csum_q;
        snap_instr_d = snap_instr_q;
        snap_arith_d = snap_arith_q;
        snap_mem_d   = snap_mem_q;
        snap_stall_d = snap_stall_q;
        tx_valid_d   = tx_valid_q;
        tx_data_d    = tx_data_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
                if (trigger_c) begin
                    snap_instr_d = instruction_count;
                    snap_arith_d = aritmetric_count;
                    snap_mem_d   = memory_count;
                    snap_stall_d = stall_count;
                    byte_idx_d   = '0;
                    csum_d       = '0;
                    tx_valid_d   = 1'b1;
                    tx_data_d    = HEADER;
                    busy_d       = 1'b1;
                    state_d      = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx.tx_ready) begin
                    csum_d = csum_acc_c;
                    if (byte_idx_q == IDX_W'(LAST_IDX)) begin
                        tx_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                        tx_data_d  = frame_byte(byte_idx_d, csum_acc_c, snap_instr_q,
                                                snap_arith_q, snap_mem_q, snap_stall_q);
                    end
                end
            end
            ST_DONE: begin
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/perf_counter_reporter.md
# perf_counter_reporter

Downstream consumer of the special-register manager's performance counters. When the program signals completion, or software requests a dump, the block snapshots the four 19-bit counters (instruction, arithmetic, memory, stall). It then streams them as a fixed 14-byte frame over a valid/ready byte interface to the debug UART transmitter. Snapshotting decouples the frame from counter updates that occur during transmission.

## Interface
- `HEADER`, default 8'hA5: frame start byte.
- `clk`  in  1: system clock; all state updates on rising edge.
- `rst`  in  1: asynchronous, active-low reset (0 = reset).
- `finish`  in  1: program-complete level from the core.
- `report_req`  in  1: single-cycle manual dump request.
- `instruction_count`  in  19: counter input.
- `aritmetric_count`  in  19: counter input.
- `memory_count`  in  19: counter input.
- `stall_count`  in  19: counter input.
- `tx_ready`  in  1: sink can accept a byte this cycle.
- `tx_valid`  out  1: `tx_data` holds a valid byte.
- `tx_data`  out  8: frame byte.
- `busy`  out  1: a frame is in progress.
- `done`  out  1: one-cycle pulse after the last byte is accepted.

## Operation
- **States:**
  - IDLE: `tx_valid`=0, `busy`=0.
  - SEND: `tx_valid`=1, `busy`=1.
  - DONE: one cycle, `done`=1, `busy`=0.
  - DONE → IDLE unconditionally.
- **Trigger:** in IDLE, a trigger is `finish`=1 with `finish_q`=0 (rising edge), or `report_req`=1.
  - Simultaneous `finish` edge and `report_req` start exactly one frame.
  - Triggers in SEND or DONE are ignored, not queued.
- **`finish_q`:** registered copy of `finish`. It resets to 1, so `finish` already high at reset release does not trigger.
- **On trigger:**
  - The four counters are captured into snapshot registers.
  - `byte_idx`←0, checksum←0, state←SEND.
  - Snapshot registers are not updated again until the next trigger.
- **Frame order (`byte_idx` 0..13):**
  - 0: `HEADER`.
  - 1–3: instruction count.
  - 4–6: arithmetic count.
  - 7–9: memory count.
  - 10–12: stall count.
  - 13: checksum.
- **Counter encoding:** each counter is zero-extended to 24 bits and sent MSB byte first. The top byte's bits 7:3 are always 0.
- **Checksum:** XOR of bytes 0–12. It accumulates on each accepted byte, including the header.
- **Handshake:**
  - A byte transfers on a rising edge with `tx_valid`=1 and `tx_ready`=1.
  - While `tx_valid`=1 and `tx_ready`=0, `tx_data` is held stable.
  - `tx_valid` never drops mid-frame.
- **Frame end:** acceptance of byte 13 moves the state to DONE.

## Timing
- **Reset values:** `tx_valid`=0, `tx_data`=0, `busy`=0, `done`=0, state IDLE, `byte_idx`=0, snapshots=0, checksum=0.
- **Reset is immediate:** assertion mid-frame aborts it. Outputs go to reset values without waiting for a clock edge, and no partial frame resumes.
- **Start latency:** the edge that samples the trigger also sets `tx_valid`=1 and `tx_data`=`HEADER`. `tx_valid` is visible in the following cycle.
- **Throughput:** with `tx_ready` held at 1, one byte per cycle with no bubbles, so 14 cycles from `tx_valid` rise to `done` rise.
- **Byte advance:** the byte after an accepted byte is presented on the same edge as the acceptance.
- **`done`:** high exactly one cycle after the edge accepting byte 13. `tx_valid` is 0 in that cycle.
- **Re-trigger:** the earliest next trigger is the cycle after DONE. `finish` held high does not re-trigger; it must fall and rise again.
- **Counter changes:** counter inputs changing during SEND do not alter the frame.

## Test plan
- **Basic frame:** counters instr=5, arith=3, mem=2, stall=0; `tx_ready`=1; pulse `finish` high.
  - Required bytes: A5, 00 00 05, 00 00 03, 00 00 02, 00 00 00, A1.
  - `done` pulses once, 14 cycles after `tx_valid` rises.
- **Max values:** all counters 19'h7FFFF; `report_req` pulse.
  - Bytes 1–12 are 07 FF FF repeated four times.
  - Checksum = A5^07^FF^FF^07^FF^FF^07^FF^FF^07^FF^FF = A5.
- **Backpressure:** `tx_ready` follows the pattern 1,0,0,1,0,1… during the basic frame.
  - `tx_data` is stable across every stall.
  - The byte sequence is unchanged.
  - `done` occurs after exactly 14 accepts.
- **Snapshot isolation and retrigger:**
  - Increment the counter inputs every cycle during SEND; the frame carries the trigger-cycle values.
  - Hold `finish` high after `done`; no second frame starts.
  - Drop `finish` and raise it again; a second frame starts.
- **Trigger collisions:**
  - `finish` edge and `report_req` in the same cycle: one frame.
  - `report_req` during SEND: ignored.
  - `finish` high at reset release: no frame.
- **Reset mid-frame:** assert `rst`=0 during byte 6.
  - `tx_valid`, `busy` and `done` go to 0 immediately.
  - After release, a new `report_req` produces a full, correct frame starting with A5.
